// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, fixed-latency imem requests, a small
// instruction FIFO toward decode, and branch redirect with flush.
module fetch_unit #(
    parameter int            N        = 64,
    parameter int            DEPTH    = 2,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst,
    output logic [N-1:0] inst_pc,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [N-1:0]  pc;
    logic          inflight;
    logic [N-1:0]  inflight_pc;
    logic [CW-1:0] count;

    logic [31:0]   fifo_inst [DEPTH];
    logic [N-1:0]  fifo_pc   [DEPTH];
    logic [31:0]   nxt_inst  [DEPTH];
    logic [N-1:0]  nxt_pc    [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit_used;
    logic [CW:0]   credit_limit;
    logic [CW-1:0] widx;

    assign inst_valid = (count != '0);
    assign inst       = fifo_inst[0];
    assign inst_pc    = fifo_pc[0];
    assign pop        = inst_valid & inst_ready;
    assign push       = inflight & ~redirect;

    // A pop this cycle frees a slot, so it counts as credit for a new request.
    assign credit_used  = {1'b0, count} + (CW + 1)'(inflight);
    assign credit_limit = (CW + 1)'(DEPTH) + (CW + 1)'(pop);
    assign issue        = (state == RUN) & ~redirect & (credit_used < credit_limit);

    assign imem_req  = issue;
    assign imem_addr = pc;

    assign widx = pop ? count - CW'(1) : count;

    // Head always lives in entry 0; a pop shifts the queue down by one.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_inst[i] = fifo_inst[i];
            nxt_pc[i]   = fifo_pc[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt_inst[i] = fifo_inst[i + 1];
                nxt_pc[i]   = fifo_pc[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == widx) begin
                    nxt_inst[i] = imem_rdata;
                    nxt_pc[i]   = inflight_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            state <= RUN;
            if (redirect) begin
                count    <= '0;
                inflight <= 1'b0;
                pc       <= {redirect_pc[N-1:2], 2'b00};
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + N'(4);
                    inflight_pc <= pc;
                end
                count <= count + CW'(push) - CW'(pop);
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_inst[i] <= nxt_inst[i];
                    fifo_pc[i]   <= nxt_pc[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed run, backpressure, redirects,
// mid-stream reset, and PC wrap on a second instance.
module tb_fetch_unit;

    localparam int            N       = 64;
    localparam int            DEPTH   = 2;
    localparam logic [N-1:0]  WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic [31:0]  imem_rdata;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [N-1:0] inst_pc;
    logic         redirect;
    logic [N-1:0] redirect_pc;

    logic         reset_w;
    logic         imem_req_w;
    logic [N-1:0] imem_addr_w;
    logic [31:0]  imem_rdata_w;
    logic         inst_valid_w;
    logic         inst_ready_w;
    logic [31:0]  inst_w;
    logic [N-1:0] inst_pc_w;
    logic         redirect_w;
    logic [N-1:0] redirect_pc_w;

    int total  = 0;
    int passed = 0;

    logic [N-1:0] exp_q [$];
    logic [N-1:0] expw_q[$];
    logic [N-1:0] e;
    logic [N-1:0] ew;

    fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset(reset_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready_w),
        .inst(inst_w), .inst_pc(inst_pc_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w)
    );

    function automatic logic [31:0] mem_word(input logic [N-1:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Synchronous instruction memory, one-cycle latency.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= mem_word(imem_addr);
        if (imem_req_w) imem_rdata_w <= mem_word(imem_addr_w);
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every accepted instruction is matched against the scoreboard.
    always @(negedge clk) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst", {32'b0, inst}, {32'b0, mem_word(e)});
            end
        end
        if (inst_valid_w && inst_ready_w) begin
            if (expw_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_wrap_inst: got pc %h, expected no instruction", inst_pc_w);
            end else begin
                ew = expw_q.pop_front();
                check("wrap_inst_pc", inst_pc_w, ew);
                check("wrap_inst", {32'b0, inst_w}, {32'b0, mem_word(ew)});
            end
        end
        if (reset && !redirect && dut.inflight && (int'(dut.count) == DEPTH) && !(inst_valid && inst_ready)) begin
            total++;
            $display("FAIL fifo_overflow: got push into full fifo, expected none");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push_run(input logic [N-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + N'(4 * i));
    endtask

    initial begin
        reset = 1'b0; reset_w = 1'b0;
        inst_ready = 1'b1; inst_ready_w = 1'b1;
        redirect = 1'b0; redirect_pc = '0;
        redirect_w = 1'b0; redirect_pc_w = '0;

        cyc(); neg();
        check("rst_req", N'(imem_req), N'(0));
        check("rst_valid", N'(inst_valid), N'(0));
        repeat (2) cyc();

        // C0: reset released, still IDLE
        reset = 1'b1; reset_w = 1'b1;
        push_run('0, 13);
        expw_q.push_back(WRAP_PC);
        expw_q.push_back(WRAP_PC + 64'd4);
        expw_q.push_back(64'd0);
        expw_q.push_back(64'd4);
        neg();
        check("c0_req", N'(imem_req), N'(0));
        check("c0_addr", imem_addr, '0);
        check("c0_valid", N'(inst_valid), N'(0));
        check("c0_inst", N'(inst), N'(0));
        check("c0_inst_pc", inst_pc, '0);

        cyc(); neg();  // C1
        check("c1_req", N'(imem_req), N'(1));
        check("c1_addr", imem_addr, '0);
        check("c1_valid", N'(inst_valid), N'(0));
        check("wrap_c1_addr", imem_addr_w, WRAP_PC);
        cyc(); neg();  // C2
        check("c2_addr", imem_addr, 64'd4);
        check("c2_valid", N'(inst_valid), N'(0));
        cyc(); neg();  // C3
        check("c3_valid", N'(inst_valid), N'(1));
        check("wrap_c3_addr", imem_addr_w, 64'd0);
        repeat (3) cyc();  // C6
        cyc();             // C7
        inst_ready_w = 1'b0;
        repeat (3) cyc();  // C10

        // C11..C15: decode stalls
        cyc();
        inst_ready = 1'b0;
        neg();
        check("stall_req_c11", N'(imem_req), N'(0));
        check("stall_pc_c11", inst_pc, 64'd32);
        for (int k = 12; k <= 15; k++) begin
            cyc(); neg();
            check("stall_req", N'(imem_req), N'(0));
            check("stall_valid", N'(inst_valid), N'(1));
            check("stall_pc", inst_pc, 64'd32);
            check("stall_inst", N'(inst), N'(mem_word(64'd32)));
        end
        cyc();  // C16
        inst_ready = 1'b1;
        neg();
        check("resume_req", N'(imem_req), N'(1));
        check("resume_addr", imem_addr, 64'd40);
        repeat (3) cyc();  // C19

        // C20: redirect coincident with pop and push
        cyc();
        redirect = 1'b1; redirect_pc = 64'h2000;
        push_run(64'h2000, 4);
        neg();
        check("redir_a_req", N'(imem_req), N'(0));
        cyc();  // C21
        redirect = 1'b0;
        neg();
        check("redir_a_valid", N'(inst_valid), N'(0));
        check("redir_a_req1", N'(imem_req), N'(1));
        check("redir_a_addr", imem_addr, 64'h2000);
        cyc(); neg();  // C22
        check("redir_a_valid2", N'(inst_valid), N'(0));
        check("redir_a_addr2", imem_addr, 64'h2004);
        cyc(); neg();  // C23
        check("redir_a_valid3", N'(inst_valid), N'(1));
        repeat (3) cyc();  // C26

        // C27: redirect while credit is exhausted and a response is arriving
        cyc();
        inst_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h1003;
        push_run(64'h1000, 5);
        neg();
        check("redir_b_req", N'(imem_req), N'(0));
        cyc();  // C28
        redirect = 1'b0; inst_ready = 1'b1;
        neg();
        check("redir_b_valid", N'(inst_valid), N'(0));
        check("redir_b_addr", imem_addr, 64'h1000);
        check("redir_b_req1", N'(imem_req), N'(1));
        cyc(); neg();  // C29
        check("redir_b_valid2", N'(inst_valid), N'(0));
        cyc(); neg();  // C30
        check("redir_b_valid3", N'(inst_valid), N'(1));
        check("redir_b_pc", inst_pc, 64'h1000);
        repeat (3) cyc();  // C33

        // C34..C36: reset with a request in flight
        cyc();
        reset = 1'b0;
        for (int k = 35; k <= 36; k++) begin
            cyc(); neg();
            check("midrst_valid", N'(inst_valid), N'(0));
            check("midrst_req", N'(imem_req), N'(0));
        end
        cyc();  // C37
        reset = 1'b1;
        push_run('0, 5);
        neg();
        check("rerun_idle_req", N'(imem_req), N'(0));
        check("rerun_idle_addr", imem_addr, '0);
        cyc(); neg();  // C38
        check("rerun_req", N'(imem_req), N'(1));
        check("rerun_addr", imem_addr, '0);
        cyc(); neg();  // C39
        check("rerun_valid", N'(inst_valid), N'(0));
        repeat (5) cyc();  // C40..C44

        cyc();  // C45
        inst_ready = 1'b0;
        repeat (3) cyc();
        neg();
        check("sb_drained", N'(exp_q.size()), N'(0));
        check("wrap_sb_drained", N'(expw_q.size()), N'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
